// File: rtl/serial_word_source_if.sv
// serial_word_source_if: word-load handshake and serial bit stream of serial_word_source.
//   din   : parallel word offered by the upstream producer
//   load  : load request, accepted when ready is also 1
//   ready : source can accept a word this cycle
//   x     : serial data bit (LSB first)
//   xv    : x carries a valid bit this cycle
//   done  : marks the last valid bit of a word
// master = word producer, slave = serial_word_source.
interface serial_word_source_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             load;
    logic             ready;
    logic             x;
    logic             xv;
    logic             done;

    modport master (
        output din,
        output load,
        input  ready,
        input  x,
        input  xv,
        input  done
    );

    modport slave (
        input  din,
        input  load,
        output ready,
        output x,
        output xv,
        output done
    );
endinterface

// File: rtl/serial_word_source.sv
// serial_word_source: accepts a parallel word over a load/ready handshake and
// shifts it out LSB-first on x, one bit per clock, with a bit-valid strobe and
// an end-of-word pulse. A word loaded during the final bit cycle follows with
// no idle gap.
// Ports:
//   CLK : clock, rising edge
//   CLR : synchronous active-high reset
//   bus : serial_word_source_if.slave (din, load, ready, x, xv, done)
// Optional feature: define SER_PARITY_EN to append an even-parity bit (^word)
// after each word's MSB; done/ready then move to the parity cycle.
module serial_word_source #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 CLR,
    serial_word_source_if.slave  bus
);
    localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
`ifdef SER_PARITY_EN
        PAR   = 2'd2,
`endif
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sr, sr_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             last_c;
    logic             ready_c;
    logic             accept_c;
    logic             x_c;
    logic             xv_c;
`ifdef SER_PARITY_EN
    logic             par, par_nx;
`endif

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
`ifdef SER_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            sr    <= sr_nx;
            cnt   <= cnt_nx;
`ifdef SER_PARITY_EN
            par   <= par_nx;
`endif
        end
    end

    // Next-state, datapath update and output decode
    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        cnt_nx   = cnt;
        x_c      = 1'b0;
        xv_c     = 1'b0;
`ifdef SER_PARITY_EN
        par_nx   = par;
        last_c   = (state == PAR);
`else
        last_c   = (state == SHIFT) && (cnt == LAST);
`endif
        ready_c  = (state == IDLE) || last_c;
        accept_c = bus.load && ready_c;

        case (state)
            SHIFT: begin
                x_c   = sr[0];
                xv_c  = 1'b1;
                sr_nx = sr >> 1;
                // cnt holds at LAST; only a new accept returns it to 0
                if (cnt == LAST) begin
`ifdef SER_PARITY_EN
                    state_nx = PAR;
`else
                    state_nx = IDLE;
`endif
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
`ifdef SER_PARITY_EN
            PAR: begin
                x_c      = par;
                xv_c     = 1'b1;
                state_nx = IDLE;
            end
`endif
            default: ;
        endcase

        // An accept in the final bit cycle overrides the return to IDLE
        if (accept_c) begin
            sr_nx    = bus.din;
            cnt_nx   = '0;
            state_nx = SHIFT;
`ifdef SER_PARITY_EN
            par_nx   = ^bus.din;
`endif
        end
    end

    assign bus.ready = ready_c;
    assign bus.x     = x_c;
    assign bus.xv    = xv_c;
    assign bus.done  = last_c;
endmodule

// File: tb/tb_serial_word_source.sv
// tb_serial_word_source: directed vector table for the documented scenarios,
// then random load/clear traffic checked against a bit-queue reference model.
module tb_serial_word_source;
    localparam int unsigned WIDTH = 8;

    typedef struct {
        logic       clr;
        logic       load;
        logic [7:0] din;
        logic       x;
        logic       xv;
        logic       done;
        logic       ready;
    } vec_t;

    typedef struct {
        logic b;
        logic d;
    } bit_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;
    vec_t tab[$];
    bit_t mq[$];

    serial_word_source_if #(.WIDTH(WIDTH)) bus ();

    serial_word_source #(.WIDTH(WIDTH)) dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic add(input logic c, input logic l, input logic [7:0] d,
                       input logic x, input logic xv, input logic dn, input logic r);
        vec_t v;
        v.clr = c; v.load = l; v.din = d;
        v.x = x; v.xv = xv; v.done = dn; v.ready = r;
        tab.push_back(v);
    endtask

    task automatic chk(input string nm, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endtask

    // Reference model: the wire is a queue of pending bits; the head is on x now.
    task automatic model_edge(input logic c, input logic l, input logic [7:0] d);
        bit_t nb;
        logic rdy;
        if (c) begin
            mq.delete();
        end else begin
            rdy = (mq.size() <= 1);
            if (mq.size() > 0) void'(mq.pop_front());
            if (l && rdy) begin
                for (int i = 0; i < WIDTH; i++) begin
                    nb.b = d[i];
                    nb.d = 1'b0;
                    mq.push_back(nb);
                end
`ifdef SER_PARITY_EN
                nb.b = ^d;
                nb.d = 1'b0;
                mq.push_back(nb);
`endif
                mq[mq.size()-1].d = 1'b1;
            end
        end
    endtask

    task automatic apply(input logic c, input logic l, input logic [7:0] d);
        clr      = c;
        bus.load = l;
        bus.din  = d;
        @(negedge clk);
    endtask

    task automatic advance(input logic c, input logic l, input logic [7:0] d);
        @(posedge clk);
        model_edge(c, l, d);
        #1;
    endtask

    task automatic bits8(input logic [7:0] w, input int dn_at, input int ld_at, input logic [7:0] ld_din);
        // Expected stream of w, LSB first, done/ready at bit dn_at, optional load request at ld_at
        for (int k = 0; k < 8; k++)
            add(1'b0, (k == ld_at), (k == ld_at) ? ld_din : 8'h00,
                w[k], 1'b1, (k == dn_at), (k == dn_at));
    endtask

    initial begin
        logic       c, l;
        logic [7:0] d;
        logic       ex, exv, edn, erd;
        vec_t       v;

        bus.load = 1'b0;
        bus.din  = '0;

        // Reset, no word accepted under CLR
        add(1, 1, 8'hFF, 0, 0, 0, 1);
        add(1, 1, 8'hFF, 0, 0, 0, 1);
        add(0, 0, 8'h00, 0, 0, 0, 1);
`ifndef SER_PARITY_EN
        // Single word 8'hB4 -> 0,0,1,0,1,1,0,1
        add(0, 1, 8'hB4, 0, 0, 0, 1);
        bits8(8'hB4, 7, -1, 8'h00);
        add(0, 0, 8'h00, 0, 0, 0, 1);
        // Back-to-back 8'hA5 then 8'h3C loaded in the done cycle
        add(0, 1, 8'hA5, 0, 0, 0, 1);
        bits8(8'hA5, 7, 7, 8'h3C);
        bits8(8'h3C, 7, -1, 8'h00);
        add(0, 0, 8'h00, 0, 0, 0, 1);
        // Ignored load of 8'hFF at bit 3 of 8'h96
        add(0, 1, 8'h96, 0, 0, 0, 1);
        bits8(8'h96, 7, 3, 8'hFF);
        add(0, 0, 8'h00, 0, 0, 0, 1);
        add(0, 0, 8'h00, 0, 0, 0, 1);
        // Reset after bit 4 of 8'h0F: word aborted, no done
        add(0, 1, 8'h0F, 0, 0, 0, 1);
        add(0, 0, 8'h00, 1, 1, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 0);
        add(1, 1, 8'h55, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++) add(0, 0, 8'h00, 0, 0, 0, 1);
`else
        // 8'h07 with parity -> 1,1,1,0,0,0,0,0 then parity 1, done on 9th
        add(0, 1, 8'h07, 0, 0, 0, 1);
        bits8(8'h07, -1, -1, 8'h00);
        add(0, 0, 8'h00, 1, 1, 1, 1);
        add(0, 0, 8'h00, 0, 0, 0, 1);
`endif

        // Prime the DUT out of its unknown power-up state
        apply(1'b1, 1'b0, 8'h00);
        advance(1'b1, 1'b0, 8'h00);

        for (int i = 0; i < tab.size(); i++) begin
            v = tab[i];
            apply(v.clr, v.load, v.din);
            chk($sformatf("tab%0d.ready", i), bus.ready, v.ready);
            chk($sformatf("tab%0d.xv", i),    bus.xv,    v.xv);
            chk($sformatf("tab%0d.x", i),     bus.x,     v.x);
            chk($sformatf("tab%0d.done", i),  bus.done,  v.done);
            advance(v.clr, v.load, v.din);
        end

        // Random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            c = ($urandom_range(0, 39) == 0);
            l = ($urandom_range(0, 2) != 0);
            d = 8'($urandom);
            apply(c, l, d);
            if (mq.size() > 0) begin
                ex = mq[0].b; exv = 1'b1; edn = mq[0].d;
            end else begin
                ex = 1'b0; exv = 1'b0; edn = 1'b0;
            end
            erd = (mq.size() <= 1);
            chk($sformatf("rnd%0d.ready", i), bus.ready, erd);
            chk($sformatf("rnd%0d.xv", i),    bus.xv,    exv);
            chk($sformatf("rnd%0d.x", i),     bus.x,     ex);
            chk($sformatf("rnd%0d.done", i),  bus.done,  edn);
            advance(c, l, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/serial_word_source.md
# serial_word_source

Upstream stage for the serial sequence detector. It accepts a parallel word through a load/ready handshake and shifts it out LSB-first, one bit per clock, on `x`. A bit-valid strobe and an end-of-word pulse accompany the stream. Back-to-back words stream with no idle gap, so the downstream Mealy detector sees a continuous bit sequence. An optional even-parity bit can be appended after each word.

## Interface
- `WIDTH`, default 8: data word width in bits; legal range 2..32.
- `CLK`, input, 1 bit: clock; all state changes on the rising edge.
- `CLR`, input, 1 bit: reset, synchronous, active-high.
- `din`, input, WIDTH bits: parallel word; sampled only on an accepted load.
- `load`, input, 1 bit: load request; accepted on the rising edge where `load` and `ready` are both 1.
- `ready`, output, 1 bit: block can accept a word this cycle.
- `x`, output, 1 bit: serial data bit to the detector.
- `xv`, output, 1 bit: `x` carries a valid bit this cycle.
- `done`, output, 1 bit: one-cycle pulse marking the last valid bit of a word.

## Operation
- States:
  - IDLE: nothing in flight.
  - SHIFT: data bits going out.
  - PAR: parity bit going out; exists only with the macro defined.
- Datapath: WIDTH-bit shift register `sr`, plus bit counter `cnt` of width clog2(WIDTH).
- Accept (IDLE or final bit cycle, `load`=1):
  - `sr`<=`din`, `cnt`<=0, state<=SHIFT.
  - Latch a parity register with ^`din` when parity is enabled.
- SHIFT:
  - `x`=`sr[0]`, `xv`=1.
  - Each edge: `sr`<=`sr`>>1 and `cnt`<=`cnt`+1.
- Leaving SHIFT, at `cnt`=WIDTH-1:
  - Without parity: go to SHIFT again if a new word is accepted, otherwise IDLE.
  - With parity: go to PAR.
- PAR: `x`=latched parity, `xv`=1. Next state is SHIFT if a new word is accepted, otherwise IDLE.
- `ready` = IDLE, or the final bit cycle of the word:
  - without parity: SHIFT with `cnt`=WIDTH-1;
  - with parity: PAR.
- `load` while `ready`=0 is ignored. `din` is not sampled and nothing is queued.
- `done`=1 exactly during the final bit cycle, the same cycle in which `ready` rises for back-to-back streaming.
- IDLE: `x`=0, `xv`=0, `done`=0.
- Outputs decode from registers only. There is no combinational path from `load` or `din` to `x`, `xv` or `done`. `ready` depends on state only.

## Timing
- Reset values, on the first edge with `CLR`=1:
  - state=IDLE, `sr`=0, `cnt`=0.
  - `ready`=1, `x`=0, `xv`=0, `done`=0.
- `CLR` asserted mid-word aborts the word. Remaining bits are discarded and no `done` is produced.
- `CLR` has priority over a simultaneous `load`; that word is not accepted.
- Latency: a word accepted at edge N drives bit k during the cycle after edge N+k, for k=0..WIDTH-1.
- Word length on the wire:
  - without parity: WIDTH cycles per word;
  - with parity: WIDTH+1 cycles per word.
- Back-to-back: a load accepted in the final bit cycle puts the new bit 0 in the very next cycle. `xv` stays 1 continuously.
- `cnt` never exceeds WIDTH-1. It wraps to 0 only via a new accept.

## Configuration
- Macro `SER_PARITY_EN`.
- Defined:
  - PAR state exists and one even-parity bit (^word) follows each word's MSB.
  - `done` and `ready` move to the PAR cycle.
  - 9 cycles per word at WIDTH=8.
- Undefined:
  - PAR state and parity register are absent.
  - `done` and `ready` assert on the MSB cycle.
  - 8 cycles per word at WIDTH=8.

## Test plan
- Reset: hold `CLR`=1 for 2 cycles with `load`=1 and `din`=8'hFF.
  - Required: `ready`=1, `xv`=0, `x`=0, `done`=0 throughout.
  - Required: no word is accepted.
- Single word, no parity: load 8'hB4.
  - Required: `x`=0,0,1,0,1,1,0,1 on 8 consecutive cycles with `xv`=1.
  - Required: `done`=1 only on the 8th of these cycles, then IDLE.
- Back-to-back: load 8'hA5, then assert `load` with 8'h3C during the `done` cycle.
  - Required: 16 contiguous `xv` cycles: 1,0,1,0,0,1,0,1, then 0,0,1,1,1,1,0,0.
  - Required: two `done` pulses, 8 cycles apart.
- Ignored load: pulse `load` with 8'hFF at bit 3 of a word in flight.
  - Required: the in-flight stream is unchanged.
  - Required: the block returns to IDLE after the word; the 8'hFF word never appears on `x`.
- Reset mid-word: assert `CLR` after bit 4 of 8'h0F.
  - Required: on the next edge `xv`=0, `x`=0, `ready`=1.
  - Required: no `done` pulse for 8'h0F.
- With `SER_PARITY_EN`: load 8'h07.
  - Required: `x`=1,1,1,0,0,0,0,0, then parity bit 1.
  - Required: `done` is asserted only on the 9th cycle.
